// File: rtl/cordic_pkg.sv
// Shared definitions for the host-side SPI master that talks to the CORDIC engine.
// Holds the controller state encoding, SPI word sizing and a byte-count helper.
package cordic_pkg;

  localparam int CORDIC_DW      = 16;
  localparam int DATA_WIDTH_SPI = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SHIFT = 3'd1,
    WR_GAP   = 3'd2,
    WAIT_RDY = 3'd3,
    RD_SHIFT = 3'd4,
    FINISH   = 3'd5
  } state_e;

  function automatic int spi_bytes(input int width);
    return width / DATA_WIDTH_SPI;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI mode-0 clock generator: divides i_clk by CLK_DIV per half-period while enabled.
// rise_en_o/fall_en_o mark the cycle in which sclk is driven 0->1 / 1->0.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic last_i,
  output logic sclk_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap      = en_i && (cnt_q == CNT_MAX);
  assign rise_en_o = wrap && !sclk_q;
  assign fall_en_o = wrap && sclk_q;
  assign sclk_o    = sclk_q;

  // With last_i set the rise strobe still fires (it marks end of phase) but sclk stays low.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      if (sclk_q) begin
        sclk_d = 1'b0;
      end else if (!last_i) begin
        sclk_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/cordic_spi_host.sv
// Host-side SPI master for the CORDIC engine: writes an angle, waits for data_ready,
// reads back cos and sin, then pulses done (with timeout_err if the engine never answered).
module cordic_spi_host
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH_CORDIC = CORDIC_DW,
  parameter int CLK_DIV           = 4,
  parameter int CS_GAP            = 2,
  parameter int TIMEOUT           = 1024
) (
  input  logic                         i_clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DATA_WIDTH_CORDIC-1:0] angle,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic [DATA_WIDTH_CORDIC-1:0] cos_out,
  output logic [DATA_WIDTH_CORDIC-1:0] sin_out,
  output logic                         sclk,
  output logic                         mosi,
  output logic                         cs_n,
  input  logic                         miso,
  input  logic                         data_ready
);

  localparam int DW      = DATA_WIDTH_CORDIC;
  localparam int WR_BITS = spi_bytes(DW) * DATA_WIDTH_SPI;
  localparam int RD_BITS = 2 * WR_BITS;
  localparam int BCW     = $clog2(RD_BITS + 1);
  localparam int TOW     = $clog2(TIMEOUT + 1);
  localparam int GPW     = $clog2(CS_GAP + 2);

  localparam logic [BCW-1:0] WR_LAST  = BCW'(WR_BITS);
  localparam logic [BCW-1:0] RD_LAST  = BCW'(RD_BITS);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
  localparam logic [GPW-1:0] GAP_LAST = GPW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  state_e               state_q, state_d;
  logic [DW-2:0]        tx_q, tx_d;
  logic [RD_BITS-1:0]   rx_q, rx_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [TOW-1:0]       to_q, to_d;
  logic [GPW-1:0]       gap_q, gap_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic [DW-1:0]        cos_q, cos_d;
  logic [DW-1:0]        sin_q, sin_d;
  logic                 rdy_meta_q, rdy_sync_q;

  logic shifting, phase_last, rise_en, fall_en;

  assign shifting   = (state_q == WR_SHIFT) || (state_q == RD_SHIFT);
  assign phase_last = (state_q == WR_SHIFT) ? (bit_q == WR_LAST) : (bit_q == RD_LAST);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .i_clk    (i_clk),
    .rst_n    (rst_n),
    .en_i     (shifting),
    .last_i   (phase_last),
    .sclk_o   (sclk),
    .rise_en_o(rise_en),
    .fall_en_o(fall_en)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    to_d    = to_q;
    gap_d   = gap_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = angle[DW-2:0];
          mosi_d  = angle[DW-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          err_d   = 1'b0;
          state_d = WR_SHIFT;
        end
      end
      WR_SHIFT: begin
        // The strobe after the final falling edge closes the phase instead of raising sclk.
        if (rise_en) begin
          if (phase_last) begin
            cs_n_d  = 1'b1;
            gap_d   = '0;
            state_d = WR_GAP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        if (fall_en) begin
          mosi_d = tx_q[DW-2];
          tx_d   = {tx_q[DW-3:0], 1'b0};
        end
      end
      WR_GAP: begin
        if (gap_q == GAP_LAST) begin
          to_d    = '0;
          state_d = WAIT_RDY;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        if (rdy_sync_q) begin
          cs_n_d  = 1'b0;
          mosi_d  = 1'b0;
          bit_d   = '0;
          state_d = RD_SHIFT;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RD_SHIFT: begin
        if (rise_en) begin
          if (phase_last) begin
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            cos_d   = rx_q[RD_BITS-1 -: DW];
            sin_d   = rx_q[DW-1:0];
            state_d = FINISH;
          end else begin
            bit_d = bit_q + 1'b1;
            rx_d  = {rx_q[RD_BITS-2:0], miso};
          end
        end
      end
      FINISH: begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_q      <= '0;
      to_q       <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      cos_q      <= '0;
      sin_q      <= '0;
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_q      <= bit_d;
      to_q       <= to_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      cos_q      <= cos_d;
      sin_q      <= sin_d;
      rdy_meta_q <= data_ready;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign cos_out     = cos_q;
  assign sin_out     = sin_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;

endmodule

// File: tb/tb_cordic_spi_host.sv
// Directed bench for cordic_spi_host: behavioural mode-0 SPI slave plus data_ready driver,
// two DUT instances (CLK_DIV=4 and CLK_DIV=1, both TIMEOUT=64).
module tb_cordic_spi_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] angle = '0;
  logic        miso = 1'b0;
  logic        data_ready = 1'b0;
  logic        sel = 1'b0;

  logic        busy0, done0, terr0, sclk0, mosi0, csn0;
  logic        busy1, done1, terr1, sclk1, mosi1, csn1;
  logic [15:0] cos0, sin0, cos1, sin1;

  always #5 clk = ~clk;

  cordic_spi_host #(.DATA_WIDTH_CORDIC(16), .CLK_DIV(4), .CS_GAP(2), .TIMEOUT(64)) dut0 (
    .i_clk(clk), .rst_n(rst_n), .start(start0), .angle(angle),
    .busy(busy0), .done(done0), .timeout_err(terr0), .cos_out(cos0), .sin_out(sin0),
    .sclk(sclk0), .mosi(mosi0), .cs_n(csn0), .miso(miso), .data_ready(data_ready)
  );

  cordic_spi_host #(.DATA_WIDTH_CORDIC(16), .CLK_DIV(1), .CS_GAP(2), .TIMEOUT(64)) dut1 (
    .i_clk(clk), .rst_n(rst_n), .start(start1), .angle(angle),
    .busy(busy1), .done(done1), .timeout_err(terr1), .cos_out(cos1), .sin_out(sin1),
    .sclk(sclk1), .mosi(mosi1), .cs_n(csn1), .miso(miso), .data_ready(data_ready)
  );

  logic        m_sclk, m_cs, m_mosi, m_done, m_terr, m_busy;
  logic [15:0] m_cos, m_sin;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_cs   = sel ? csn1  : csn0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_done = sel ? done1 : done0;
  assign m_terr = sel ? terr1 : terr0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_cos  = sel ? cos1  : cos0;
  assign m_sin  = sel ? sin1  : sin0;

  int checks = 0;
  int failures = 0;

  // ---- slave model / monitor configuration (written by the initial block only)
  int          cyc = 0;
  int          rdy_mode = 0;    // 0: never, 1: delayed after write frame, 2: always high
  int          rdy_delay = 20;
  logic [31:0] slv_tx = '0;
  int          clr_tok = 0;

  // ---- monitor state (written by the monitor only)
  int          clr_seen = 0;
  logic        p_sclk = 1'b0, p_cs = 1'b1;
  bit          slv_wr = 1'b1, first_in_frame = 1'b0, rdy_arm = 1'b0;
  logic [15:0] slv_angle = '0;
  logic [31:0] rd_sh = '0;
  int rise_cnt, rd_rises, last_rise, min_per, max_per, cs_fall_cnt, cs_fall_cyc;
  int first_rise_dly, last_fall_cyc, cs_rise_dly, wr_end_cyc, rd_start_cyc;
  int done_cnt, done_cyc, stray_terr, rdy_cnt;
  logic done_terr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr_tok != clr_seen) begin
      clr_seen = clr_tok;
      slv_wr = 1'b1; rdy_arm = 1'b0; miso = 1'b0; slv_angle = '0;
      rise_cnt = 0; rd_rises = 0; last_rise = -1; min_per = 1000; max_per = 0;
      cs_fall_cnt = 0; done_cnt = 0; stray_terr = 0; done_terr = 1'b0;
      first_rise_dly = -1; cs_rise_dly = -1; wr_end_cyc = 0; rd_start_cyc = 0;
      data_ready = 1'b0;
    end
    if (rdy_mode == 2) data_ready = 1'b1;
    if (p_cs && !m_cs) begin
      cs_fall_cnt++; cs_fall_cyc = cyc; last_rise = -1; first_in_frame = 1'b1;
      if (slv_wr) slv_angle = '0;
      else begin
        rd_sh = slv_tx; miso = slv_tx[31]; rd_rises = 0; rd_start_cyc = cyc;
        if (rdy_mode == 1) data_ready = 1'b0;
      end
    end
    if (!m_cs && !p_sclk && m_sclk) begin
      rise_cnt++;
      if (first_in_frame) begin first_rise_dly = cyc - cs_fall_cyc; first_in_frame = 1'b0; end
      if (last_rise >= 0) begin
        if (cyc - last_rise < min_per) min_per = cyc - last_rise;
        if (cyc - last_rise > max_per) max_per = cyc - last_rise;
      end
      last_rise = cyc;
      if (slv_wr) slv_angle = {slv_angle[14:0], m_mosi};
      else rd_rises++;
    end
    if (!m_cs && p_sclk && !m_sclk) begin
      last_fall_cyc = cyc;
      if (!slv_wr) begin rd_sh = rd_sh << 1; miso = rd_sh[31]; end
    end
    if (!p_cs && m_cs) begin
      cs_rise_dly = cyc - last_fall_cyc;
      if (slv_wr) begin
        slv_wr = 1'b0; wr_end_cyc = cyc;
        if (rdy_mode == 1) begin rdy_arm = 1'b1; rdy_cnt = rdy_delay; end
      end else begin
        slv_wr = 1'b1; miso = 1'b0;
      end
    end
    if (rdy_arm) begin
      if (rdy_cnt == 0) begin data_ready = 1'b1; rdy_arm = 1'b0; end
      else rdy_cnt--;
    end
    if (m_done) begin done_cnt++; done_cyc = cyc; done_terr = m_terr; end
    else if (m_terr) stray_terr++;
    p_sclk = m_sclk; p_cs = m_cs;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic slave_clear();
    clr_tok++;
    tick();
  endtask

  task automatic pulse_start(input logic [15:0] a);
    angle = a;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (m_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if ({csn0, sclk0, mosi0, busy0, done0, terr0} !== 6'b100000) begin
      failures++; $display("FAIL reset_ctl0: got %b exp 100000", {csn0, sclk0, mosi0, busy0, done0, terr0}); end
    checks++; if ({cos0, sin0} !== 32'h0) begin
      failures++; $display("FAIL reset_res0: got %h exp 00000000", {cos0, sin0}); end
    checks++; if ({csn1, sclk1, mosi1, busy1, done1, terr1} !== 6'b100000) begin
      failures++; $display("FAIL reset_ctl1: got %b exp 100000", {csn1, sclk1, mosi1, busy1, done1, terr1}); end
    checks++; if ({cos1, sin1} !== 32'h0) begin
      failures++; $display("FAIL reset_res1: got %h exp 00000000", {cos1, sin1}); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    bit seen;
    sel = 1'b0; rdy_mode = 1; rdy_delay = 20; slv_tx = {16'h1234, 16'hABCD};
    slave_clear();
    pulse_start(16'h3243);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b exp 1", busy0); end
    wait_done(2000, seen);
    checks++; if (!seen) begin failures++; $display("FAIL basic_done: got no done exp done"); end
    checks++; if (slv_angle !== 16'h3243) begin failures++; $display("FAIL basic_angle: got %h exp 3243", slv_angle); end
    checks++; if (m_cos !== 16'h1234) begin failures++; $display("FAIL basic_cos: got %h exp 1234", m_cos); end
    checks++; if (m_sin !== 16'hABCD) begin failures++; $display("FAIL basic_sin: got %h exp abcd", m_sin); end
    checks++; if (m_terr !== 1'b0) begin failures++; $display("FAIL basic_terr: got %b exp 0", m_terr); end
    checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done: got %b exp 1", m_busy); end
    checks++; if (rise_cnt !== 48) begin failures++; $display("FAIL basic_rises: got %0d exp 48", rise_cnt); end
    checks++; if (min_per !== 8 || max_per !== 8) begin
      failures++; $display("FAIL basic_period: got %0d..%0d exp 8..8", min_per, max_per); end
    checks++; if (first_rise_dly !== 4) begin failures++; $display("FAIL basic_first_rise: got %0d exp 4", first_rise_dly); end
    checks++; if (cs_rise_dly !== 4) begin failures++; $display("FAIL basic_cs_rise: got %0d exp 4", cs_rise_dly); end
    tick();
    checks++; if ({m_done, m_busy, m_terr} !== 3'b000) begin
      failures++; $display("FAIL basic_after_done: got %b exp 000", {m_done, m_busy, m_terr}); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_cnt: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_timeout();
    bit seen;
    sel = 1'b0; rdy_mode = 0;
    slave_clear();
    pulse_start(16'h1000);
    wait_done(2000, seen);
    checks++; if (!seen) begin failures++; $display("FAIL to_done: got no done exp done"); end
    checks++; if (m_terr !== 1'b1) begin failures++; $display("FAIL to_terr: got %b exp 1", m_terr); end
    checks++; if (done_cyc - wr_end_cyc < 64 || done_cyc - wr_end_cyc > 69) begin
      failures++; $display("FAIL to_latency: got %0d exp 64..69", done_cyc - wr_end_cyc); end
    checks++; if ({m_cos, m_sin} !== {16'h1234, 16'hABCD}) begin
      failures++; $display("FAIL to_hold: got %h exp 1234abcd", {m_cos, m_sin}); end
    checks++; if (slv_angle !== 16'h1000) begin failures++; $display("FAIL to_angle: got %h exp 1000", slv_angle); end
    repeat (20) tick();
    checks++; if (rise_cnt !== 16) begin failures++; $display("FAIL to_rises: got %0d exp 16", rise_cnt); end
    checks++; if (cs_fall_cnt !== 1 || m_cs !== 1'b1) begin
      failures++; $display("FAIL to_cs: got falls=%0d cs=%b exp falls=1 cs=1", cs_fall_cnt, m_cs); end
    checks++; if (stray_terr !== 0) begin failures++; $display("FAIL to_stray_terr: got %0d exp 0", stray_terr); end
  endtask

  task automatic test_start_busy();
    bit seen;
    sel = 1'b0; rdy_mode = 1; rdy_delay = 20; slv_tx = {16'h0F1E, 16'h2D3C};
    slave_clear();
    pulse_start(16'h2468);
    repeat (40) tick();
    pulse_start(16'hFFFF);
    wait_done(2000, seen);
    checks++; if (!seen) begin failures++; $display("FAIL busy_done: got no done exp done"); end
    repeat (300) tick();
    checks++; if (slv_angle !== 16'h2468) begin failures++; $display("FAIL busy_angle: got %h exp 2468", slv_angle); end
    checks++; if (done_cnt !== 1 || cs_fall_cnt !== 2) begin
      failures++; $display("FAIL busy_single: got done=%0d falls=%0d exp done=1 falls=2", done_cnt, cs_fall_cnt); end
    checks++; if ({m_cos, m_sin} !== {16'h0F1E, 16'h2D3C}) begin
      failures++; $display("FAIL busy_result: got %h exp 0f1e2d3c", {m_cos, m_sin}); end
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    bit hit;
    sel = 1'b0; rdy_mode = 1; rdy_delay = 20; slv_tx = {16'h1234, 16'hABCD};
    slave_clear();
    pulse_start(16'h7777);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      if (!slv_wr && rd_rises == 10) hit = 1'b1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_reach_read: got no 10th read bit exp reached"); end
    rst_n = 1'b0;
    #1;
    checks++; if ({csn0, sclk0, busy0, done0} !== 4'b1000) begin
      failures++; $display("FAIL rst_abort: got %b exp 1000", {csn0, sclk0, busy0, done0}); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (done_cnt !== 0 || {cos0, sin0} !== 32'h0) begin
      failures++; $display("FAIL rst_no_done: got done=%0d res=%h exp done=0 res=0", done_cnt, {cos0, sin0}); end
    slv_tx = {16'h5A5A, 16'hC3C3};
    slave_clear();
    pulse_start(16'h0001);
    wait_done(2000, seen);
    checks++; if (!seen) begin failures++; $display("FAIL rst_next_done: got no done exp done"); end
    checks++; if (slv_angle !== 16'h0001) begin failures++; $display("FAIL rst_next_angle: got %h exp 0001", slv_angle); end
    checks++; if ({m_cos, m_sin, m_terr} !== {16'h5A5A, 16'hC3C3, 1'b0}) begin
      failures++; $display("FAIL rst_next_result: got %h exp 5a5ac3c3 terr 0", {m_cos, m_sin, m_terr}); end
  endtask

  task automatic test_fast_clk();
    bit seen;
    sel = 1'b1; rdy_mode = 2; slv_tx = {16'h0F0F, 16'hF0F0};
    slave_clear();
    repeat (4) tick();
    pulse_start(16'h8001);
    wait_done(500, seen);
    checks++; if (!seen) begin failures++; $display("FAIL fast_done: got no done exp done"); end
    checks++; if ({m_cos, m_sin, m_terr} !== {16'h0F0F, 16'hF0F0, 1'b0}) begin
      failures++; $display("FAIL fast_result: got %h exp 0f0ff0f0 terr 0", {m_cos, m_sin, m_terr}); end
    checks++; if (slv_angle !== 16'h8001) begin failures++; $display("FAIL fast_angle: got %h exp 8001", slv_angle); end
    checks++; if (min_per !== 2 || max_per !== 2 || rise_cnt !== 48) begin
      failures++; $display("FAIL fast_timing: got per %0d..%0d rises %0d exp 2..2 rises 48", min_per, max_per, rise_cnt); end
    checks++; if (rd_start_cyc - wr_end_cyc < 3 || rd_start_cyc - wr_end_cyc > 5) begin
      failures++; $display("FAIL fast_gap: got %0d exp 3..5", rd_start_cyc - wr_end_cyc); end
    rdy_mode = 0;
    sel = 1'b0;
    slave_clear();
  endtask

  task automatic test_back_to_back();
    bit seen;
    sel = 1'b0; rdy_mode = 1; rdy_delay = 20; slv_tx = {16'h2222, 16'h3333};
    slave_clear();
    pulse_start(16'h1111);
    wait_done(2000, seen);
    checks++; if (!seen || {m_cos, m_sin} !== {16'h2222, 16'h3333}) begin
      failures++; $display("FAIL b2b_first: got seen=%b res=%h exp 1 22223333", seen, {m_cos, m_sin}); end
    slv_tx = {16'h5555, 16'h6666};
    tick();
    pulse_start(16'h4444);
    checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy %b exp 1", m_busy); end
    wait_done(2000, seen);
    checks++; if (!seen || done_cnt !== 2) begin
      failures++; $display("FAIL b2b_done: got seen=%b done=%0d exp 1 2", seen, done_cnt); end
    checks++; if (slv_angle !== 16'h4444) begin failures++; $display("FAIL b2b_angle: got %h exp 4444", slv_angle); end
    checks++; if ({m_cos, m_sin, m_terr} !== {16'h5555, 16'h6666, 1'b0}) begin
      failures++; $display("FAIL b2b_result: got %h exp 55556666 terr 0", {m_cos, m_sin, m_terr}); end
    checks++; if (rise_cnt !== 96) begin failures++; $display("FAIL b2b_rises: got %0d exp 96", rise_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_start_busy();
    test_reset_mid_read();
    test_fast_clk();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
